// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pkg: opcode encoding, response record and buffer occupancy states       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOTA = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] OP_SLTU = 3'b110;
  localparam logic [OP_W-1:0] OP_ILL  = 3'b111;

  // Widest supported datapath; narrower results are zero-extended into the record.
  localparam int ALU_WMAX = 32;

  typedef struct packed {
    logic [ALU_WMAX-1:0] result;
    logic                carry;
    logic                zero;
    logic                err;
  } alu_rsp_t;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_rsp_fifo: DEPTH-entry response buffer with EMPTY/PARTIAL/FULL tracking  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_rsp_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  alu_rsp_t data_i,
  input  logic     pop_i,
  output alu_rsp_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  occ_state_e    state_q, state_d;
  alu_rsp_t      mem_q [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign push_ok = push_i && (state_q != OCC_FULL);
  assign pop_ok  = pop_i  && (state_q != OCC_EMPTY);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    state_d  = state_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    case (state_q)
      OCC_EMPTY: begin
        if (push_ok) state_d = (DEPTH == 1) ? OCC_FULL : OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (push_ok && !pop_ok && (occ_q == CW'(DEPTH - 1)))
          state_d = OCC_FULL;
        else if (pop_ok && !push_ok && (occ_q == CW'(1)))
          state_d = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (pop_ok) state_d = (DEPTH == 1) ? OCC_EMPTY : OCC_PARTIAL;
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= OCC_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
    end
  end

  // Storage needs no reset: entries are only observed while occupancy is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (state_q == OCC_FULL);
  assign empty_o = (state_q == OCC_EMPTY);

endmodule
`default_nettype wire

// File: rtl/alu_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_responder: valid/ready ALU with buffered registered responses          |
// | Optional ALU_RSP_COUNT_EN adds the 8-bit completed-response counter.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [7:0]       rsp_count
);

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  alu_rsp_t         rsp_d;
  alu_rsp_t         rsp_head;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             carry;
  logic             err;
  logic             a_lt_b;

  always_comb begin
    sum    = {1'b0, req_a} + {1'b0, req_b};
    diff   = {1'b0, req_a} - {1'b0, req_b};
    a_lt_b = (req_a < req_b);
    res    = '0;
    carry  = 1'b0;
    err    = 1'b0;
    case (req_op)
      OP_AND:  res = req_a & req_b;
      OP_OR:   res = req_a | req_b;
      OP_XOR:  res = req_a ^ req_b;
      OP_NOTA: res = ~req_a;
      OP_ADD:  begin res = sum[WIDTH-1:0];  carry = sum[WIDTH]; end
      OP_SUB:  begin res = diff[WIDTH-1:0]; carry = a_lt_b;     end
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_ILL:  err = 1'b1;
    endcase
    rsp_d        = '0;
    rsp_d.result = ALU_WMAX'(res);
    rsp_d.carry  = carry;
    rsp_d.zero   = (res == '0);
    rsp_d.err    = err;
  end

  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;

  alu_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (rsp_d),
    .pop_i   (pop),
    .data_o  (rsp_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Fields read as zero while nothing is buffered, matching the reset view.
  assign rsp_result = rsp_valid ? rsp_head.result[WIDTH-1:0] : '0;
  assign rsp_carry  = rsp_valid && rsp_head.carry;
  assign rsp_zero   = rsp_valid && rsp_head.zero;
  assign rsp_err    = rsp_valid && rsp_head.err;

  generate
    if (WIDTH < ALU_WMAX) begin : g_head_hi
      logic unused_head_hi;
      assign unused_head_hi = |rsp_head.result[ALU_WMAX-1:WIDTH];
    end
  endgenerate

`ifdef ALU_RSP_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (pop) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  assign rsp_count = count_q;
`else
  assign rsp_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: doc/alu_responder.md
# alu_responder

Request/response wrapper around the integer ALU datapath: accepts one operation per cycle (opcode plus two operands) on a valid/ready request port and returns the registered result and flags on a valid/ready response port. It buffers up to two results so a stalled consumer does not stall the datapath immediately. It is the hardware responder that the ALU gate-level benches drive from the initiator side, and it sits between the top-level sequencer and the per-operation gate modules.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- DEPTH, 2, response buffer entries (power of two)
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, synchronous and active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_op  in  3  opcode (alu_pkg encoding)
- req_a  in  WIDTH  operand A
- req_b  in  WIDTH  operand B
- rsp_valid  out  1  head response present
- rsp_ready  in  1  consumer accepts head
- rsp_result  out  WIDTH  result
- rsp_carry  out  1  carry out (ADD) / borrow (SUB); 0 otherwise
- rsp_zero  out  1  result == 0
- rsp_err  out  1  illegal opcode
- rsp_count  out  8  completed-response counter (see Configuration)

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOT A (B ignored), 100 ADD, 101 SUB (A−B), 110 SLTU (result = {0…,A<B} unsigned), 111 illegal.
- Illegal opcode: result 0, carry 0, zero 1, err 1; it is still a normal response.
- ADD: {carry,result} = A+B, computed at WIDTH+1 bits. SUB: result = A−B mod 2^WIDTH, carry = 1 when A<B (borrow).
- Request accepted when req_valid && req_ready at a rising edge; the computed result is written to the buffer tail on that same edge.
- req_ready = buffer not full; it does not depend combinationally on rsp_ready.
- rsp_* fields show the buffer head; rsp_valid = buffer not empty. A pop occurs on rsp_valid && rsp_ready.
- Simultaneous push and pop with 1..DEPTH−1 entries: occupancy unchanged, FIFO order preserved.
- Occupancy states: EMPTY (0), PARTIAL, FULL (DEPTH). EMPTY→PARTIAL on push only. PARTIAL→FULL on push without pop. FULL→PARTIAL on pop (no push is possible when FULL). PARTIAL→EMPTY on pop without push of the last entry.
- Pointers wrap modulo DEPTH. Occupancy is a log2(DEPTH)+1-bit counter.
- rsp_count increments by 1 on every pop and wraps 255→0.

## Timing
- Latency: a request accepted at edge N gives rsp_valid high after edge N (visible in cycle N+1) if the buffer was empty.
- Throughput: 1 op/cycle while rsp_ready is held high.
- Outputs are registered or derived from registered state only. There is no combinational path from req_* to rsp_*.
- Reset values: req_ready 1, rsp_valid 0, rsp_result 0, rsp_carry 0, rsp_zero 0, rsp_err 0, rsp_count 0.
- rst mid-operation: all buffered responses are discarded and the pointers, occupancy and counter are cleared on that edge. A request presented during the rst cycle is not accepted.
- Once rsp_valid is high, the rsp_* fields hold stable until popped.

## Configuration
- ALU_RSP_COUNT_EN defined: the rsp_count counter is implemented as described.
- Not defined: no counter register; rsp_count is tied to 8'd0.
- The macro does not affect handshake behaviour or latency.

## Structure
- Package alu_pkg: opcode localparams (OP_AND … OP_ILL), op width 3, and the response struct typedef {result, carry, zero, err}.
- Sub-module alu_rsp_fifo (DEPTH × response struct, push/pop/full/empty). The datapath case statement stays in alu_responder.

## Test plan
- OR A=1100 B=0011, rsp_ready=1 → next cycle result 1111, zero 0, carry 0, err 0. Then A=0000 B=0011 → 0011.
- ADD 1111+0001 → result 0000, carry 1, zero 1. SUB 0011−0101 → result 1110, carry 1.
- Opcode 111 with A=1010 B=0101 → result 0000, zero 1, err 1. SLTU 0010,0111 → 0001.
- Backpressure: rsp_ready=0, three back-to-back requests (AND, XOR, NOT) → first two accepted, req_ready=0 on the third. Raising rsp_ready drains them in AND, XOR, NOT order, and the third is accepted the cycle after the first pop.
- Streaming with rsp_ready=1 for 260 requests → one response per cycle; rsp_count wraps to 4 (when ALU_RSP_COUNT_EN is defined; 0 otherwise).
- Buffer FULL, then rst asserted for one cycle → rsp_valid 0, req_ready 1, rsp_count 0 on the next cycle; no stale response appears afterwards.
